gin_mcc_fifo: RTL and testbench
===============================

Name: gin_mcc_fifo

Overview:
- Buffered multicast controller for the global input network (GIN). One instance sits in front of each PE or row.
- It compares each incoming bus tag against a scan-configured ID/mask pair and captures matching words into a small FIFO. The PE drains the FIFO under a valid/ready handshake.
- Non-matching traffic is never stalled by this block.
- Successor to the unbuffered tag-match controller. Adds masked (range) multicast matching, parametrised buffering, occupancy reporting and a scan-safe configuration window.

Parameters:
- DATA_WIDTH, 64, payload width in bits.
- TAG_WIDTH, 4, width of tag, ID and mask.
- FIFO_DEPTH, 2, buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  bus payload.
- tag  input  TAG_WIDTH  destination tag of the current bus word.
- enable_in  input  1  bus word valid.
- ready_out  output  1  upstream ready.
- data_out  output  DATA_WIDTH  head-of-FIFO payload to the PE.
- enable_out  output  1  data_out valid.
- ready_in  input  1  PE ready to consume.
- fill_count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
- scan_en_id  input  1  configuration shift enable.
- scan_in_id  input  1  configuration serial in.
- scan_out_id  output  1  configuration serial out.

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high.
- Config register cfg = {id[TAG_WIDTH-1:0], mask[TAG_WIDTH-1:0]}, 2*TAG_WIDTH bits.
  - When scan_en_id=1: cfg <= {scan_in_id, cfg[2*TAG_WIDTH-1:1]}.
  - scan_out_id = cfg[0], driven directly from the register.
  - The first bit shifted in ends up as mask[0] after 2*TAG_WIDTH shifts.
- match = (((tag ^ id) & ~mask) == 0). A mask bit of 1 makes that tag bit don't-care. mask=0 gives an exact match.
- full = (fill_count == FIFO_DEPTH); empty = (fill_count == 0).
- ready_out:
  - 0 while scan_en_id=1.
  - Otherwise !match | !full.
  - Does not depend on ready_in; no combinational ready_in -> ready_out path.
- push = enable_in & match & !full & !scan_en_id.
  - Non-matching words are accepted (ready_out=1) and discarded.
- Downstream:
  - enable_out = !empty.
  - data_out = head entry when !empty, else all zeros.
- pop = enable_out & ready_in.
- Latency: a pushed word appears at data_out the cycle after the push. FIFO order is preserved.
- Simultaneous push and pop:
  - Both occur; fill_count is unchanged.
  - When full, no push occurs even if a pop happens in the same cycle (ready_out already 0).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- fill_count tracks pushes minus pops; it never exceeds FIFO_DEPTH and never underflows.
- Reset (including mid-operation):
  - Pointers and fill_count go to 0; enable_out=0; data_out=0; cfg=0 (id=0, mask=0). Buffered data is discarded.
  - ready_out then follows the combinational rule: 1 unless scan_en_id=1.
- Scan mid-operation: pushes are blocked, pops continue, and match uses the current (shifting) cfg.
- Memory contents need no reset; only valid entries are ever presented.

Optional Feature:
- Macro: GIN_MCC_BYPASS_EN.
- Defined:
  - Condition: empty & enable_in & match & ready_in & !scan_en_id.
  - In that cycle enable_out=1 and data_out=data_in combinationally, and the word is not written to the FIFO (zero-latency cut-through).
  - If ready_in=0, the word is pushed normally.
  - fill_count is unaffected by a bypass.
- Undefined: one-cycle minimum latency; no combinational data_in -> data_out path.

Test Plan:
1. Config via scan:
   - Stimulus: shift 8 bits giving id=4'b0101, mask=4'b0000; send tag=5 with data 64'hA5, ready_in=1.
   - Response: enable_out=1 and data_out=64'hA5 the next cycle (same cycle with bypass); fill_count returns to 0. scan_out_id reproduces the shifted stream delayed 8 cycles.
2. Masked multicast:
   - Stimulus: id=4'b0100, mask=4'b0011; tags 4,5,6,7,8 each valid.
   - Response: only 4-7 are captured; tag 8 is accepted with ready_out=1 and not captured.
3. Backpressure:
   - Stimulus: FIFO_DEPTH=2, ready_in=0; three matching words D0, D1, D2.
   - Response: fill_count reaches 2; ready_out=0 on D2, which holds. Raise ready_in: D0, D1, D2 come out in order and fill_count ends at 0.
4. Full with simultaneous pop:
   - Stimulus: full FIFO, ready_in=1, matching enable_in.
   - Response: one pop, no push, fill_count=1; the push occurs the next cycle.
5. Reset mid-stream:
   - Stimulus: assert reset with fill_count=2.
   - Response: next cycle fill_count=0, enable_out=0, data_out=0, cfg=0. A subsequent tag=0 word matches.
6. Scan during traffic:
   - Stimulus: scan_en_id=1 with FIFO holding 1 word and ready_in=1.
   - Response: ready_out=0; the word drains; no new push until scan_en_id=0.

Source files
------------

// File: rtl/gin_mcc_fifo_if.sv
// Bus/PE handshake bundle for gin_mcc_fifo.
// Handshake: a word moves when its valid (enable_in / enable_out) and the matching ready (ready_out / ready_in) are both high at a rising clk edge.
interface gin_mcc_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  enable_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  enable_out;
    logic                  ready_in;

    modport master (
        output data_in, tag, enable_in, ready_in,
        input  ready_out, data_out, enable_out
    );

    modport slave (
        input  data_in, tag, enable_in, ready_in,
        output ready_out, data_out, enable_out
    );
endinterface

// File: rtl/gin_mcc_fifo.sv
// GIN multicast controller: scan-configured id/mask tag match feeding a small FIFO towards the PE.
// Optional zero-latency cut-through when GIN_MCC_BYPASS_EN is defined.
module gin_mcc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    gin_mcc_fifo_if.slave                    bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill_count,
    input  logic                             scan_en_id,
    input  logic                             scan_in_id,
    output logic                             scan_out_id
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CFG_W = 2 * TAG_WIDTH;

    logic [CFG_W-1:0]      cfg;
    logic [TAG_WIDTH-1:0]  id;
    logic [TAG_WIDTH-1:0]  mask;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  match;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  bypass;

    assign id          = cfg[CFG_W-1:TAG_WIDTH];
    assign mask        = cfg[TAG_WIDTH-1:0];
    assign scan_out_id = cfg[0];

    // Mask bits set to 1 turn the corresponding tag bit into a don't-care.
    assign match = ((bus.tag ^ id) & ~mask) == '0;
    assign full  = (fill_count == CNT_W'(FIFO_DEPTH));
    assign empty = (fill_count == '0);

    // Non-matching words are always taken (and dropped), so unrelated traffic never stalls.
    assign bus.ready_out = !scan_en_id && (!match || !full);
    assign pop           = !empty && bus.ready_in;

`ifdef GIN_MCC_BYPASS_EN
    assign bypass         = empty && bus.enable_in && match && bus.ready_in && !scan_en_id;
    assign bus.enable_out = !empty || bypass;
    assign bus.data_out   = bypass ? bus.data_in : (empty ? '0 : mem[rd_ptr]);
`else
    assign bypass         = 1'b0;
    assign bus.enable_out = !empty;
    assign bus.data_out   = empty ? '0 : mem[rd_ptr];
`endif

    assign push = bus.enable_in && match && !full && !scan_en_id && !bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (scan_en_id) begin
                cfg <= {scan_in_id, cfg[CFG_W-1:1]};
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_count <= fill_count + CNT_W'(1);
                2'b01:   fill_count <= fill_count - CNT_W'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Payload storage carries no reset; only entries between the pointers are ever shown.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_gin_mcc_fifo.sv
// Directed bench for gin_mcc_fifo: queue model checked every cycle plus hand-computed expectations.
module tb_gin_mcc_fifo;
    localparam int DW    = 64;
    localparam int TW    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] fill_count;
    logic          scan_en_id;
    logic          scan_in_id;
    logic          scan_out_id;

    gin_mcc_fifo_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    gin_mcc_fifo #(
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fill_count (fill_count),
        .scan_en_id (scan_en_id),
        .scan_in_id (scan_in_id),
        .scan_out_id(scan_out_id)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endfunction

    // scoreboard: model of what the buffer holds, plus the model configuration
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   got_q[$];
    logic [2*TW-1:0] m_cfg;
    bit              model_valid = 1'b0;

    function automatic bit tag_hits(input logic [TW-1:0] t, input logic [2*TW-1:0] c);
        logic [TW-1:0] cid;
        logic [TW-1:0] cmask;
        cid   = c[2*TW-1:TW];
        cmask = c[TW-1:0];
        for (int b = 0; b < TW; b++) begin
            if (!cmask[b] && (t[b] != cid[b])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_bypass();
`ifdef GIN_MCC_BYPASS_EN
        return exp_q.size() == 0 && bus.enable_in && tag_hits(bus.tag, m_cfg) &&
               bus.ready_in && !scan_en_id;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit m_hit;
        bit m_pop;
        bit m_push;
        if (reset) begin
            exp_q.delete();
            m_cfg       = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_hit  = tag_hits(bus.tag, m_cfg);
            m_pop  = (exp_q.size() != 0) && bus.ready_in;
            m_push = bus.enable_in && m_hit && (exp_q.size() < DEPTH) && !scan_en_id &&
                     !model_bypass();
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(bus.data_in);
            if (scan_en_id) m_cfg = {scan_in_id, m_cfg[2*TW-1:1]};
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        logic          e_en;
        logic [DW-1:0] e_data;
        logic          e_rdy;
        if (model_valid) begin
            e_en   = exp_q.size() != 0;
            e_data = e_en ? exp_q[0] : '0;
            if (model_bypass()) begin
                e_en   = 1'b1;
                e_data = bus.data_in;
            end
            e_rdy = !scan_en_id && (!tag_hits(bus.tag, m_cfg) || exp_q.size() < DEPTH);
            chk("enable_out", bus.enable_out, e_en);
            chk("data_out", bus.data_out, e_data);
            chk("ready_out", bus.ready_out, e_rdy);
            chk("fill_count", fill_count, exp_q.size());
            chk("scan_out_id", scan_out_id, m_cfg[0]);
            if (!reset && bus.enable_out && bus.ready_in) got_q.push_back(bus.data_out);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [TW-1:0] t, input logic [DW-1:0] d,
                         input logic rdy);
        bus.enable_in = en;
        bus.tag       = t;
        bus.data_in   = d;
        bus.ready_in  = rdy;
    endtask

    task automatic scan_byte(input logic [7:0] v, output logic [7:0] seen);
        for (int k = 0; k < 8; k++) begin
            scan_en_id = 1'b1;
            scan_in_id = v[k];
            seen[k]    = scan_out_id;
            step();
        end
        scan_en_id = 1'b0;
        scan_in_id = 1'b0;
    endtask

    initial begin
        logic [7:0] seen;
        int         base;

        reset      = 1'b1;
        scan_en_id = 1'b0;
        scan_in_id = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step();
        step();
        chk("reset_fill", fill_count, 0);
        chk("reset_enable_out", bus.enable_out, 0);
        chk("reset_ready_out", bus.ready_out, 1);
        reset = 1'b0;

        // 1: id=0101 mask=0000 -> cfg byte 8'h50, streamed LSB first
        scan_byte(8'h50, seen);
        chk("t1_scan_out_first", seen, 8'h00);
        scan_byte(8'h50, seen);
        chk("t1_scan_out_delayed", seen, 8'h50);
        drive(1'b1, 4'd5, 64'hA5, 1'b1);
`ifdef GIN_MCC_BYPASS_EN
        #1;
        chk("t1_bypass_enable", bus.enable_out, 1);
        chk("t1_bypass_data", bus.data_out, 64'hA5);
        step();
        drive(1'b0, '0, '0, 1'b1);
`else
        step();
        drive(1'b0, '0, '0, 1'b1);
        #1;
        chk("t1_enable_out", bus.enable_out, 1);
        chk("t1_data_out", bus.data_out, 64'hA5);
        step();
`endif
        chk("t1_fill_back_to_0", fill_count, 0);

        // 2: id=0100 mask=0011 -> cfg 8'h43; tags 4..7 captured, 8 dropped
        scan_byte(8'h43, seen);
        chk("t2_old_cfg_out", seen, 8'h50);
        base = got_q.size();
        for (int t = 4; t <= 8; t++) begin
            drive(1'b1, TW'(t), 64'h100 + 64'(t), 1'b1);
            if (t == 8) begin
                #1;
                chk("t2_tag8_ready", bus.ready_out, 1);
            end
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        step();
        step();
        chk("t2_count", got_q.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("t2_word", got_q[base+i], 64'h104 + 64'(i));

        // 3+4: backpressure, then full with simultaneous pop
        base = got_q.size();
        drive(1'b1, 4'd4, 64'hD0, 1'b0);
        step();
        drive(1'b1, 4'd4, 64'hD1, 1'b0);
        step();
        drive(1'b1, 4'd4, 64'hD2, 1'b0);
        #1;
        chk("t3_ready_on_d2", bus.ready_out, 0);
        step();
        chk("t3_fill_full", fill_count, 2);
        bus.ready_in = 1'b1;
        #1;
        chk("t4_ready_full_pop", bus.ready_out, 0);
        step();
        chk("t4_fill_after_pop", fill_count, 1);
        chk("t4_head_d1", bus.data_out, 64'hD1);
        step();
        chk("t4_fill_push_pop", fill_count, 1);
        chk("t4_head_d2", bus.data_out, 64'hD2);
        drive(1'b0, '0, '0, 1'b1);
        step();
        chk("t3_fill_drained", fill_count, 0);
        chk("t3_count", got_q.size() - base, 3);
        for (int i = 0; i < 3; i++) chk("t3_order", got_q[base+i], 64'hD0 + 64'(i));

        // 5: reset with two words buffered
        drive(1'b1, 4'd6, 64'hE0, 1'b0);
        step();
        drive(1'b1, 4'd6, 64'hE1, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("t5_fill_pre", fill_count, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_fill", fill_count, 0);
        chk("t5_enable_out", bus.enable_out, 0);
        chk("t5_data_out", bus.data_out, 64'h0);
        chk("t5_cfg_bit0", scan_out_id, 0);
        drive(1'b1, 4'd0, 64'hC0, 1'b0);
        step();
        drive(1'b1, 4'd3, 64'hC3, 1'b0);
        step();
        chk("t5_tag0_kept_tag3_dropped", fill_count, 1);
        chk("t5_head", bus.data_out, 64'hC0);

        // 6: scan while one word is buffered
        base = got_q.size();
        drive(1'b1, 4'd0, 64'hF6, 1'b1);
        scan_en_id = 1'b1;
        scan_in_id = 1'b0;
        #1;
        chk("t6_ready_during_scan", bus.ready_out, 0);
        step();
        chk("t6_drained", fill_count, 0);
        chk("t6_drained_word", got_q[base], 64'hC0);
        step();
        chk("t6_no_push", fill_count, 0);
        scan_en_id = 1'b0;
        step();
`ifdef GIN_MCC_BYPASS_EN
        chk("t6_push_after_scan", fill_count, 0);
        chk("t6_bypassed_word", got_q[got_q.size()-1], 64'hF6);
`else
        chk("t6_push_after_scan", fill_count, 1);
        chk("t6_head", bus.data_out, 64'hF6);
`endif
        drive(1'b0, '0, '0, 1'b1);
        step();
        step();
        chk("final_fill", fill_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
